fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF-stage engine that consumes the hazard unit's PC controls: `pc_en` and `pcmux_sel`, plus the EX-stage `alu_out` target.
- Owns the PC register and drives the instruction-memory read port.
- Keeps at most one read outstanding and hands fetched words to the IF/ID register.
- Returns `fetch_stall` so the hazard unit can bubble the pipeline while imem is busy.

Parameters:
RESET_PC, 32'h0000_0060, PC value loaded by reset.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pc_en  in  1  hazard unit: downstream accepts / PC may change this cycle
pcmux_sel  in  pcmux_sel_t (2)  pc_plus4=0, alu_out=1, alu_mod2=2
alu_out  in  32  EX-stage jump/branch target
imem_read  out  1  read request, held until imem_resp
imem_address  out  32  word address {pc[31:2],2'b00}
imem_rdata  in  32  instruction word, valid with imem_resp
imem_resp  in  1  one-cycle read completion
ifid_valid  out  1  instruction presented to IF/ID this cycle
ifid_pc  out  32  PC of presented instruction
ifid_instr  out  32  presented instruction
fetch_stall  out  1  = !ifid_valid; hazard unit inserts a bubble

Behaviour:
- Reset, synchronous and active-high on clk:
  - pc <= RESET_PC; state <= FETCH; hold buffer invalid.
  - While rst is high: imem_read=0, ifid_valid=0, fetch_stall=1.
- Redirect:
  - redirect = pc_en && pcmux_sel != pc_plus4.
  - target = alu_out for alu_out; {alu_out[31:1],1'b0} for alu_mod2.
  - Any other encoding is treated as pc_plus4.
- Transfer = ifid_valid && pc_en && !redirect; pc <= pc+4 on transfer (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Redirect has priority over transfer. On redirect:
  - ifid_valid is forced 0 that cycle.
  - Any buffered word is discarded.
  - pc <= target.
- FETCH state:
  - imem_read=1, imem_address from pc; resp is accepted in any cycle, including the first.
  - resp && transfer: ifid_valid=1, ifid_instr=imem_rdata, ifid_pc=pc, pc advances; stay in FETCH. The new address appears next cycle with imem_read still 1.
  - resp && !pc_en: capture rdata into the hold buffer -> HOLD.
  - resp && redirect: drop data, pc <= target; stay in FETCH.
  - !resp && redirect: pc <= target -> DISCARD. The old address keeps being driven through a shadow register so the read stays stable.
  - !resp && no redirect: stay.
- HOLD state:
  - imem_read=0; ifid_valid=1 with buffered instr/pc.
  - transfer -> FETCH (pc+4); redirect -> FETCH at target; else stay.
- DISCARD state:
  - imem_read=1 with the old address held; ifid_valid=0.
  - redirect updates pc (last redirect wins) and stays in DISCARD.
  - On resp: drop rdata -> FETCH at current pc.
- Address stability: imem_address may change only in the cycle after imem_resp or after reset. A redirect never changes the address of an in-flight read.
- Latency: combinational memory (resp in the request cycle) gives 1 instruction per cycle with no stall. An N-cycle memory gives fetch_stall=1 for N-1 cycles per instruction.
- Reset mid-read: the in-flight request is abandoned; imem_read drops while rst is high and the fetch restarts at RESET_PC.

Decomposition:
- pcmux package: reuse the existing pcmux_sel_t.
- rv32i_types: add fetch_state_t {FETCH, HOLD, DISCARD}.
- Sub-module fetch_buffer: one-entry valid/pc/instr register with load and clear.
- Target/PC+4 selection stays inline.

Test Plan:
- Reset then zero-wait memory, pc_en=1 always -> addresses 0x60, 0x64, 0x68 on consecutive cycles; ifid_valid=1 every cycle after reset.
- Memory with 3-cycle latency -> imem_address holds 0x60 for 3 cycles with fetch_stall=1 for 2 cycles, then ifid_instr=rdata and address becomes 0x64.
- pc_en=0 in the resp cycle for 2 cycles -> HOLD, imem_read=0, ifid_instr stable. pc_en=1 -> word handed over, next fetch at pc+4.
- jalr redirect (sel=alu_mod2, alu_out=0x0000_1235) mid-read -> old address held until resp, data dropped (ifid_valid=0), next request at 0x0000_1234.
- Back-to-back redirects in DISCARD (0x200 then 0x300) -> the fetch after resp is at 0x300 only.
- pc=0xFFFF_FFFC transfer -> next address 0x0000_0000. Assert rst during an outstanding read -> imem_read=0, next fetch at 0x60.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the IF stage: PC mux encoding from the hazard unit
// and the fetch engine state.
package fetch_unit_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    PCMUX_PC_PLUS4 = 2'd0,
    PCMUX_ALU_OUT  = 2'd1,
    PCMUX_ALU_MOD2 = 2'd2
  } pcmux_sel_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port plus the IF/ID hand-off, as seen from the
// fetch unit (master) and from the memory / IF-ID register side (slave).
interface fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  modport master (
    output imem_read, imem_address, ifid_valid, ifid_pc, ifid_instr,
    input  imem_rdata, imem_resp
  );

  modport slave (
    input  imem_read, imem_address, ifid_valid, ifid_pc, ifid_instr,
    output imem_rdata, imem_resp
  );
endinterface

// File: rtl/fetch_unit_buffer.sv
// One-entry hold buffer: keeps a fetched word and its PC while the
// downstream stage is not accepting.
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end
  end

  // NOTE: only the valid bit needs reset; the payload is never observed
  // while valid is low, so leaving it unreset saves reset routing.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// IF-stage engine: owns the PC, keeps one imem read outstanding and hands
// fetched words to IF/ID, honouring hazard-unit stalls and redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  pcmux_sel_t  pcmux_sel,
  input  logic [31:0] alu_out,
  output logic        fetch_stall,
  fetch_unit_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         buf_load, buf_clear, buf_valid;
  logic [31:0]  buf_pc, buf_instr;

  // Unknown encodings fall through to sequential fetch.
  always_comb begin
    redirect = 1'b0;
    target   = alu_out;
    case (pcmux_sel)
      PCMUX_ALU_OUT:  redirect = pc_en;
      PCMUX_ALU_MOD2: begin
        redirect = pc_en;
        target   = {alu_out[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign pc_plus4 = pc_q + PC_STEP;

  // NOTE: every output of this block gets a default before the case so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    addr_d           = addr_q;
    buf_load         = 1'b0;
    buf_clear        = 1'b0;
    bus.imem_read    = 1'b0;
    bus.imem_address = {pc_q[31:2], 2'b00};
    bus.ifid_valid   = 1'b0;
    bus.ifid_pc      = pc_q;
    bus.ifid_instr   = bus.imem_rdata;

    case (state_q)
      FETCH: begin
        bus.imem_read = 1'b1;
        addr_d        = {pc_q[31:2], 2'b00};
        if (bus.imem_resp) begin
          bus.ifid_valid = !redirect;
          if (redirect) begin
            pc_d = target;
          end else if (pc_en) begin
            pc_d = pc_plus4;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (redirect) begin
          // The shadow address keeps the in-flight read stable.
          pc_d    = target;
          state_d = DISCARD;
        end
      end
      HOLD: begin
        bus.ifid_valid = buf_valid && !redirect;
        bus.ifid_pc    = buf_pc;
        bus.ifid_instr = buf_instr;
        if (redirect) begin
          pc_d      = target;
          buf_clear = 1'b1;
          state_d   = FETCH;
        end else if (pc_en) begin
          pc_d      = pc_plus4;
          buf_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        bus.imem_read    = 1'b1;
        bus.imem_address = addr_q;
        if (redirect)      pc_d    = target;
        if (bus.imem_resp) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (rst) begin
      bus.imem_read  = 1'b0;
      bus.ifid_valid = 1'b0;
    end
  end

  assign fetch_stall = !bus.ifid_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .in_pc    (pc_q),
    .in_instr (bus.imem_rdata),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one record per clock cycle
// with inputs and hand-computed combinational outputs for that cycle.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b0;
  pcmux_sel_t  pcmux_sel = PCMUX_PC_PLUS4;
  logic [31:0] alu_out = '0;
  logic        fetch_stall;
  int          tests = 0;
  int          fails = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_en       (pc_en),
    .pcmux_sel   (pcmux_sel),
    .alu_out     (alu_out),
    .fetch_stall (fetch_stall),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pc_en;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(logic r, logic en, logic [1:0] sel, logic [31:0] alu,
                              logic resp, logic [31:0] rdata, logic e_read,
                              logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_pc, logic [31:0] e_instr);
    vec_t v;
    v.rst = r;  v.pc_en = en;  v.sel = sel;  v.alu = alu;
    v.resp = resp;  v.rdata = rdata;
    v.e_read = e_read;  v.e_addr = e_addr;  v.e_valid = e_valid;
    v.e_pc = e_pc;  v.e_instr = e_instr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1ns later; the rising edge commits.
  task automatic step(input vec_t v, input int id);
    @(negedge clk);
    rst             = v.rst;
    pc_en           = v.pc_en;
    pcmux_sel       = pcmux_sel_t'(v.sel);
    alu_out         = v.alu;
    bus.imem_resp   = v.resp;
    bus.imem_rdata  = v.rdata;
    #1;
    check($sformatf("v%0d imem_read", id), {31'd0, bus.imem_read}, {31'd0, v.e_read});
    if (v.e_read)
      check($sformatf("v%0d imem_address", id), bus.imem_address, v.e_addr);
    check($sformatf("v%0d ifid_valid", id), {31'd0, bus.ifid_valid}, {31'd0, v.e_valid});
    check($sformatf("v%0d fetch_stall", id), {31'd0, fetch_stall}, {31'd0, !v.e_valid});
    if (v.e_valid) begin
      check($sformatf("v%0d ifid_pc", id), bus.ifid_pc, v.e_pc);
      check($sformatf("v%0d ifid_instr", id), bus.ifid_instr, v.e_instr);
    end
  endtask

  localparam logic [1:0] P4 = 2'd0, AO = 2'd1, AM = 2'd2, BAD = 2'd3;

  vec_t tbl[22];

  initial begin
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;

    //              rst en sel alu           resp rdata         rd addr          vld pc            instr
    tbl[0]  = mk(1, 1, P4, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    tbl[1]  = mk(1, 1, P4, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    // zero-wait memory, one instruction per cycle
    tbl[2]  = mk(0, 1, P4, 32'h0,        1, 32'hA000_0000, 1, 32'h60,       1, 32'h60,       32'hA000_0000);
    tbl[3]  = mk(0, 1, P4, 32'h0,        1, 32'hA000_0001, 1, 32'h64,       1, 32'h64,       32'hA000_0001);
    tbl[4]  = mk(0, 1, P4, 32'h0,        1, 32'hA000_0002, 1, 32'h68,       1, 32'h68,       32'hA000_0002);
    // 3-cycle memory: two stall cycles, address held
    tbl[5]  = mk(0, 1, P4, 32'h0,        0, 32'h0,        1, 32'h6C,       0, 32'h0,        32'h0);
    tbl[6]  = mk(0, 1, P4, 32'h0,        0, 32'h0,        1, 32'h6C,       0, 32'h0,        32'h0);
    tbl[7]  = mk(0, 1, P4, 32'h0,        1, 32'hB000_0000, 1, 32'h6C,       1, 32'h6C,       32'hB000_0000);
    tbl[8]  = mk(0, 1, P4, 32'h0,        0, 32'h0,        1, 32'h70,       0, 32'h0,        32'h0);
    // stall in resp cycle -> HOLD, word stays presented
    tbl[9]  = mk(0, 0, P4, 32'h0,        1, 32'hC000_0000, 1, 32'h70,       1, 32'h70,       32'hC000_0000);
    tbl[10] = mk(0, 0, P4, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h70,       32'hC000_0000);
    tbl[11] = mk(0, 0, P4, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h70,       32'hC000_0000);
    tbl[12] = mk(0, 1, P4, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h70,       32'hC000_0000);
    tbl[13] = mk(0, 1, P4, 32'h0,        0, 32'h0,        1, 32'h74,       0, 32'h0,        32'h0);
    // jalr redirect mid-read: old address held, data dropped
    tbl[14] = mk(0, 1, AM, 32'h0000_1235, 0, 32'h0,        1, 32'h74,       0, 32'h0,        32'h0);
    tbl[15] = mk(0, 1, P4, 32'h0,        0, 32'h0,        1, 32'h74,       0, 32'h0,        32'h0);
    tbl[16] = mk(0, 1, P4, 32'h0,        1, 32'hD000_0000, 1, 32'h74,       0, 32'h0,        32'h0);
    tbl[17] = mk(0, 1, P4, 32'h0,        0, 32'h0,        1, 32'h1234,     0, 32'h0,        32'h0);
    // back-to-back redirects while discarding: last one wins
    tbl[18] = mk(0, 1, AO, 32'h200,      0, 32'h0,        1, 32'h1234,     0, 32'h0,        32'h0);
    tbl[19] = mk(0, 1, AO, 32'h300,      0, 32'h0,        1, 32'h1234,     0, 32'h0,        32'h0);
    tbl[20] = mk(0, 1, P4, 32'h0,        1, 32'hDEAD_0000, 1, 32'h1234,     0, 32'h0,        32'h0);
    tbl[21] = mk(0, 1, P4, 32'h0,        1, 32'hE000_0000, 1, 32'h300,      1, 32'h300,      32'hE000_0000);

    for (int i = 0; i < 22; i++) step(tbl[i], i);

    // Redirect in a resp cycle to the top word, then wrap to zero
    step(mk(0, 1, AO, 32'hFFFF_FFFC, 1, 32'hF000_0000, 1, 32'h304,      0, 32'h0,        32'h0),          100);
    step(mk(0, 1, P4, 32'h0,         1, 32'hF000_0001, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hF000_0001), 101);
    step(mk(0, 1, P4, 32'h0,         0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0),          102);

    // Reset during an outstanding read abandons it and restarts at 0x60
    step(mk(1, 1, P4, 32'h0,         0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0),          110);
    step(mk(0, 1, P4, 32'h0,         0, 32'h0,         1, 32'h60,       0, 32'h0,        32'h0),          111);
    step(mk(0, 1, P4, 32'h0,         1, 32'h1111_1111, 1, 32'h60,       1, 32'h60,       32'h1111_1111), 112);

    // Redirect out of HOLD drops the buffered word
    step(mk(0, 0, P4, 32'h0,         1, 32'h2222_2222, 1, 32'h64,       1, 32'h64,       32'h2222_2222), 120);
    step(mk(0, 1, AO, 32'h400,       0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0),          121);
    step(mk(0, 1, P4, 32'h0,         0, 32'h0,         1, 32'h400,      0, 32'h0,        32'h0),          122);

    // Unused mux encoding behaves as sequential fetch
    step(mk(0, 1, BAD, 32'h999,      1, 32'h3333_3333, 1, 32'h400,      1, 32'h400,      32'h3333_3333), 130);
    step(mk(0, 1, P4, 32'h0,         0, 32'h0,         1, 32'h404,      0, 32'h0,        32'h0),          131);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
